// File: rtl/time_of_day_counter.sv
// ---------------------------------------------------------------------------
// time_of_day_counter
//
// Purpose:
//   24-hour wall-clock time keeper. It watches the free-running millisecond
//   count from the upstream stage. The exact transition MS_WRAP -> 0 is taken
//   as one elapsed second. Hours, minutes and seconds are kept here for the
//   display and alarm-compare stages. A synchronous, range-checked time-set
//   port loads a new hour and minute.
//
// Parameters:
//   MS_WRAP   terminal value of the upstream millisecond count
//   MS_W      width of the millisecond input
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   miliseg    in   [MS_W-1:0] upstream millisecond count
//   set_en     in   one-cycle request to load set_hour/set_min
//   set_hour   in   [4:0] requested hour, valid 0..23
//   set_min    in   [5:0] requested minute, valid 0..59
//   hours      out  [4:0] current hour 0..23
//   minutes    out  [5:0] current minute 0..59
//   seconds    out  [5:0] current second 0..59
//   sec_pulse  out  one-cycle strobe on each seconds increment
//   day_pulse  out  one-cycle strobe on 23:59:59 -> 00:00:00
//   set_err    out  one-cycle strobe when a set request is rejected
// ---------------------------------------------------------------------------
module time_of_day_counter #(
    parameter int unsigned MS_WRAP = 1000,
    parameter int unsigned MS_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [MS_W-1:0] miliseg,
    input  logic            set_en,
    input  logic [4:0]      set_hour,
    input  logic [5:0]      set_min,
    output logic [4:0]      hours,
    output logic [5:0]      minutes,
    output logic [5:0]      seconds,
    output logic            sec_pulse,
    output logic            day_pulse,
    output logic            set_err
);

    localparam logic [MS_W-1:0] MS_WRAP_V = MS_W'(MS_WRAP);

    // Registered state
    logic [MS_W-1:0] r_ms_q;
    logic [4:0]      r_hour;
    logic [5:0]      r_min;
    logic [5:0]      r_sec;
    logic            r_sec_pulse;
    logic            r_day_pulse;
    logic            r_set_err;

    // Combinational next-state
    logic            w_tick;
    logic            w_set_ok;
    logic            w_sec_wrap;
    logic            w_min_wrap;
    logic            w_hour_wrap;
    logic            w_tick_taken;
    logic [4:0]      w_hour_nxt;
    logic [5:0]      w_min_nxt;
    logic [5:0]      w_sec_nxt;

    // A second elapses only on the exact MS_WRAP -> 0 edge. Any upstream
    // restart from another value, or a count that stays at 0, does not count.
    assign w_tick   = (r_ms_q == MS_WRAP_V) && (miliseg == '0);

    assign w_set_ok = set_en && (set_hour <= 5'd23) && (set_min <= 6'd59);

    // Explicit terminal compares keep every counter inside its legal range
    // without depending on binary overflow.
    assign w_sec_wrap  = (r_sec  == 6'd59);
    assign w_min_wrap  = (r_min  == 6'd59);
    assign w_hour_wrap = (r_hour == 5'd23);

    // A valid set takes priority over a tick that arrives on the same edge.
    // When that happens the tick is dropped.
    assign w_tick_taken = w_tick && !w_set_ok;

    // NOTE: every signal gets its default value first, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_hour_nxt = r_hour;
        w_min_nxt  = r_min;
        w_sec_nxt  = r_sec;
        if (w_set_ok) begin
            w_hour_nxt = set_hour;
            w_min_nxt  = set_min;
            w_sec_nxt  = '0;
        end else if (w_tick) begin
            w_sec_nxt = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
            if (w_sec_wrap) begin
                w_min_nxt = w_min_wrap ? 6'd0 : r_min + 6'd1;
                if (w_min_wrap) begin
                    w_hour_nxt = w_hour_wrap ? 5'd0 : r_hour + 5'd1;
                end
            end
        end
    end

    // NOTE: the state is small, so all of it is reset, including the
    // millisecond history. After reset is released no stale value can fake
    // an MS_WRAP -> 0 edge, and no pulse is produced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ms_q      <= '0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register here samples
            // values from before the edge, so the order of these lines has
            // no effect on the result.
            r_ms_q      <= miliseg;
            r_hour      <= w_hour_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_sec_pulse <= w_tick_taken;
            r_day_pulse <= w_tick_taken && w_sec_wrap && w_min_wrap && w_hour_wrap;
            r_set_err   <= set_en && !w_set_ok;
        end
    end

    assign hours     = r_hour;
    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_time_of_day_counter.sv
// ---------------------------------------------------------------------------
// tb_time_of_day_counter
//
// Directed stimulus for time_of_day_counter. A reference model keeps the
// time as a single seconds-of-day number. On every falling clock edge the
// DUT outputs are compared with that model. Hand-computed literal checks at
// key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_time_of_day_counter;

    localparam int unsigned MS_WRAP = 1000;
    localparam int unsigned MS_W    = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [MS_W-1:0] miliseg;
    logic            set_en;
    logic [4:0]      set_hour;
    logic [5:0]      set_min;
    logic [4:0]      hours;
    logic [5:0]      minutes;
    logic [5:0]      seconds;
    logic            sec_pulse;
    logic            day_pulse;
    logic            set_err;

    int n_checks = 0;
    int n_errors = 0;

    time_of_day_counter #(.MS_WRAP(MS_WRAP), .MS_W(MS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .miliseg   (miliseg),
        .set_en    (set_en),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model: time as seconds of day -------------
    int          m_tod;
    logic [31:0] m_prev;
    logic        m_sp, m_dp, m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tod  <= 0;
            m_prev <= '0;
            m_sp   <= 1'b0;
            m_dp   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            automatic bit tick  = (m_prev == MS_WRAP) && (miliseg == 0);
            automatic bit valid = set_en && (int'(set_hour) < 24) && (int'(set_min) < 60);
            m_prev <= miliseg;
            if (valid)
                m_tod <= int'(set_hour) * 3600 + int'(set_min) * 60;
            else if (tick)
                m_tod <= (m_tod + 1) % 86400;
            m_sp  <= tick && !valid;
            m_dp  <= tick && !valid && (m_tod == 86399);
            m_err <= set_en && !valid;
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        check("hours",     int'(hours),     m_tod / 3600);
        check("minutes",   int'(minutes),   (m_tod / 60) % 60);
        check("seconds",   int'(seconds),   m_tod % 60);
        check("sec_pulse", int'(sec_pulse), int'(m_sp));
        check("day_pulse", int'(day_pulse), int'(m_dp));
        check("set_err",   int'(set_err),   int'(m_err));
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic step(input int ms);
        miliseg = MS_W'(ms);
        @(posedge clk);
        #1;
    endtask

    task automatic wrap();
        step(MS_WRAP);
        step(0);
    endtask

    task automatic do_set(input int h, input int m);
        set_en   = 1'b1;
        set_hour = 5'(h);
        set_min  = 6'(m);
        @(posedge clk);
        #1;
        set_en   = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, ".h"}, int'(hours),   h);
        check({name, ".m"}, int'(minutes), m);
        check({name, ".s"}, int'(seconds), s);
    endtask

    initial begin
        reset    = 1'b0;
        miliseg  = '0;
        set_en   = 1'b0;
        set_hour = '0;
        set_min  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_time("reset", 0, 0, 0);
        check("reset.sec_pulse", int'(sec_pulse), 0);
        reset = 1'b1;

        // 1: count 0..1000 then 0 gives one second
        for (int i = 0; i <= 1000; i++) begin
            step(i);
            check("count.no_pulse", int'(sec_pulse), 0);
        end
        step(0);
        check_time("first_sec", 0, 0, 1);
        check("first_sec.sec_pulse", int'(sec_pulse), 1);
        step(0);
        check("first_sec.pulse_drop", int'(sec_pulse), 0);

        // 2: holding at 0, then a 500 -> 0 edge: no tick
        for (int i = 0; i < 10; i++) begin
            step(0);
            check("hold0.no_pulse", int'(sec_pulse), 0);
        end
        step(500);
        step(0);
        check("edge500.no_pulse", int'(sec_pulse), 0);
        step(0);
        check_time("edge500", 0, 0, 1);

        // 3: day rollover
        do_set(23, 59);
        check_time("set2359", 23, 59, 0);
        for (int i = 0; i < 59; i++) wrap();
        check_time("at235959", 23, 59, 59);
        wrap();
        check_time("rollover", 0, 0, 0);
        check("rollover.sec_pulse", int'(sec_pulse), 1);
        check("rollover.day_pulse", int'(day_pulse), 1);
        step(0);
        check("rollover.day_drop", int'(day_pulse), 0);

        // 4: range-checked set
        do_set(24, 10);
        check("bad_hour.set_err", int'(set_err), 1);
        check_time("bad_hour", 0, 0, 0);
        step(0);
        check("bad_hour.err_drop", int'(set_err), 0);
        do_set(10, 60);
        check("bad_min.set_err", int'(set_err), 1);
        check_time("bad_min", 0, 0, 0);
        do_set(12, 34);
        check("good_set.set_err", int'(set_err), 0);
        check_time("good_set", 12, 34, 0);

        // 5: a valid set beats a simultaneous tick
        step(MS_WRAP);
        miliseg = '0;
        do_set(5, 6);
        check_time("set_vs_tick", 5, 6, 0);
        check("set_vs_tick.sec_pulse", int'(sec_pulse), 0);
        wrap();
        check_time("after_set_tick", 5, 6, 1);

        // An invalid set does not block the tick.
        step(MS_WRAP);
        miliseg = '0;
        do_set(30, 0);
        check_time("badset_tick", 5, 6, 2);
        check("badset_tick.sec_pulse", int'(sec_pulse), 1);
        check("badset_tick.set_err", int'(set_err), 1);

        // 6: asynchronous reset in the middle of a cycle
        do_set(10, 20);
        for (int i = 0; i < 30; i++) wrap();
        check_time("pre_reset", 10, 20, 30);
        step(MS_WRAP);
        #2;
        reset = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0);
        check("async_reset.sec_pulse", int'(sec_pulse), 0);
        miliseg = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0);
        check("release.no_pulse", int'(sec_pulse), 0);
        wrap();
        check_time("post_reset", 0, 0, 1);
        check("post_reset.sec_pulse", int'(sec_pulse), 1);

        step(0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
